// File: rtl/seq_mult8x8_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 nibble product per cycle over four cycles.
// Optional macro MULT_STICKY_ERR_EN makes the ERR state sticky until reset.
module seq_mult8x8_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product8x8,
  output logic        done_flag,
  output logic [2:0]  state_out
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd4;  // outside 0..3 so the encoder shows "E"

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  a_reg, a_next;
  logic [7:0]  b_reg, b_next;
  logic [15:0] acc, acc_next;
  logic [1:0]  count, count_next;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;

  // Nibble selection and alignment for the current partial product.
  always_comb begin
    nib_a      = a_reg[3:0];
    nib_b      = b_reg[3:0];
    pp_shifted = '0;
    case (count)
      2'd0: begin nib_a = a_reg[3:0]; nib_b = b_reg[3:0]; end
      2'd1: begin nib_a = a_reg[7:4]; nib_b = b_reg[3:0]; end
      2'd2: begin nib_a = a_reg[3:0]; nib_b = b_reg[7:4]; end
      default: begin nib_a = a_reg[7:4]; nib_b = b_reg[7:4]; end
    endcase
    pp = {4'b0000, nib_a} * {4'b0000, nib_b};
    case (count)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd1,
      2'd2:    pp_shifted = {4'h0, pp, 4'h0};
      default: pp_shifted = {pp, 8'h00};
    endcase
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    state_next = state;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc;
    count_next = count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_next     = dataa;
          b_next     = datab;
          acc_next   = '0;
          count_next = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        if (start) begin
          // Launch while busy: freeze the partial sum and flag the error.
          state_next = ERR;
        end else begin
          acc_next   = acc + pp_shifted;
          count_next = count + 2'd1;
          if (count == 2'd3) state_next = DONE;
        end
      end
      ERR: begin
`ifdef MULT_STICKY_ERR_EN
        state_next = ERR;
`else
        if (!start) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      a_reg <= a_next;
      b_reg <= b_next;
      acc   <= acc_next;
      count <= count_next;
    end
  end

  assign product8x8 = acc;
  assign done_flag  = (state == DONE);
  assign state_out  = state;

endmodule

// File: tb/tb_seq_mult8x8_ctrl.sv
// Self-checking bench for seq_mult8x8_ctrl: directed vectors, scoreboard queue of expected products.
// Define MULT_STICKY_ERR_EN for both bench and RTL to exercise the sticky-error build.
module tb_seq_mult8x8_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product8x8;
  logic        done_flag;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic        prev_done = 1'b0;

  seq_mult8x8_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dataa      (dataa),
    .datab      (datab),
    .product8x8 (product8x8),
    .done_flag  (done_flag),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Drives a one-cycle start; the edge that follows accepts the launch.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    dataa = a;
    datab = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Four CALC cycles, then DONE must be visible.
  task automatic run_calc(input bit scramble);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("calc_state", {13'd0, state_out}, 16'd1);
      check("calc_done", {15'd0, done_flag}, 16'd0);
      if (scramble) begin
        dataa = 8'($urandom);
        datab = 8'($urandom);
      end
      tick();
    end
    @(negedge clk);
    check("done_state", {13'd0, state_out}, 16'd2);
    check("done_flag", {15'd0, done_flag}, 16'd1);
  endtask

  // Monitor: each rising done_flag presents one result to compare.
  always @(negedge clk) begin
    if (done_flag && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", product8x8, 16'hxxxx);
      end else begin
        check("product", product8x8, exp_q.pop_front());
      end
    end
    prev_done <= done_flag;
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dataa = 8'h00;
    datab = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_product", product8x8, 16'h0000);
    check("rst_done", {15'd0, done_flag}, 16'd0);
    check("rst_state", {13'd0, state_out}, 16'd0);

    // 0x12 * 0x34 = 18 * 52 = 936, then hold in DONE.
    exp_q.push_back(16'h03A8);
    launch(8'h12, 8'h34);
    run_calc(1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("hold_state", {13'd0, state_out}, 16'd2);
      check("hold_product", product8x8, 16'h03A8);
      check("hold_done", {15'd0, done_flag}, 16'd1);
    end

    // Max operands, then back-to-back relaunch straight from DONE.
    exp_q.push_back(16'hFE01);
    launch(8'hFF, 8'hFF);
    run_calc(1'b0);
    exp_q.push_back(16'h0000);
    launch(8'h00, 8'hAB);
    run_calc(1'b0);

    // start held for three edges: launch, then ERR, then stays in ERR.
    dataa = 8'h0F;
    datab = 8'h0F;
    start = 1'b1;
    tick();
    @(negedge clk);
    check("err_launch_state", {13'd0, state_out}, 16'd1);
    tick();
    @(negedge clk);
    check("err_state", {13'd0, state_out}, 16'd4);
    check("err_done", {15'd0, done_flag}, 16'd0);
    check("err_product", product8x8, 16'h0000);
    tick();
    @(negedge clk);
    check("err_hold_state", {13'd0, state_out}, 16'd4);
    start = 1'b0;
    tick();
    @(negedge clk);
`ifdef MULT_STICKY_ERR_EN
    check("err_sticky_state", {13'd0, state_out}, 16'd4);
    do_reset();
    @(negedge clk);
`endif
    check("err_exit_state", {13'd0, state_out}, 16'd0);

    // Busy launch after two accumulates: partial 0x08 + (0x04 << 4) = 0x48 stays frozen.
    launch(8'h12, 8'h34);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_err_state", {13'd0, state_out}, 16'd4);
    check("busy_err_acc", product8x8, 16'h0048);
    tick();
    @(negedge clk);
`ifdef MULT_STICKY_ERR_EN
    check("busy_err_sticky", {13'd0, state_out}, 16'd4);
    check("busy_err_acc_hold", product8x8, 16'h0048);
    do_reset();
`else
    check("busy_err_exit", {13'd0, state_out}, 16'd0);
    check("busy_err_acc_hold", product8x8, 16'h0048);
`endif

    // Reset at count=2 discards the calculation.
    launch(8'h80, 8'h02);
    tick();
    tick();
    do_reset();
    @(negedge clk);
    check("midrst_state", {13'd0, state_out}, 16'd0);
    check("midrst_product", product8x8, 16'h0000);
    check("midrst_done", {15'd0, done_flag}, 16'd0);
    exp_q.push_back(16'h0100);
    launch(8'h80, 8'h02);
    run_calc(1'b0);

    // Operand inputs scrambled during CALC must not affect the result.
    exp_q.push_back(16'h03A8);
    launch(8'h12, 8'h34);
    run_calc(1'b1);

    tick();
    tick();
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
